job_initiator: RTL and testbench
================================

// Module: job_initiator
// PURPOSE
//  Host-side initiator for the start/done handshake: issues NUM_JOBS start requests on
//  start_asyn, waits for each done_moore acknowledge, captures the result per job.
//  Sits between the top-level controller (go) and the interface unit that drives the
//  computation unit. Flags jobs that never complete (timeout) and continues with the next.
// PARAMETERS
//  NUM_JOBS     4    jobs issued per go; 1..255
//  DATA_W       8    width of result_in / result_out
//  PULSE_CYC    2    cycles start_asyn is held high per job; >=1
//  TIMEOUT_CYC  255  max cycles in WAIT_DONE before a job is abandoned; >=1
//  SYNC_STAGES  2    flops on done_moore before use; >=1
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       synchronous, active-high
//  go            in   1       start a batch; sampled only in IDLE
//  done_moore    in   1       acknowledge level from interface unit
//  result_in     in   DATA_W  computation result, valid while done_moore high
//  start_asyn    out  1       start request to interface unit
//  busy          out  1       high in every state except IDLE
//  job_idx       out  8       index of current/last job, 0..NUM_JOBS-1
//  result_out    out  DATA_W  captured result of job job_idx
//  result_valid  out  1       1-cycle pulse when result_out updated
//  timeout_err   out  1       1-cycle pulse when a job is abandoned
//  err_count     out  8       timeouts in current batch, saturates at 255
//  all_done      out  1       1-cycle pulse at end of batch
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All outputs registered.
//  - Reset: state=IDLE; start_asyn, busy, result_valid, timeout_err, all_done = 0;
//    job_idx=0; result_out=0; err_count=0; sync flops and edge register = 0.
//  - done_s = done_moore after SYNC_STAGES flops; done_prev = done_s delayed 1 cycle.
//  - done_rise = done_s & ~done_prev.
//  - FSM: IDLE -> ASSERT -> WAIT_DONE -> (CAPTURE | ABANDON) -> ASSERT or FINISH -> IDLE.
//  - IDLE: go=1 -> ASSERT next cycle; job_idx<=0, err_count<=0.
//  - ASSERT: start_asyn=1 for exactly PULSE_CYC cycles; pulse counter and
//    timeout counter cleared on entry; done_prev forced to 0 on last ASSERT cycle
//    so a stale high done_moore from the previous job is not taken as a rise.
//  - WAIT_DONE: start_asyn=0; timeout counter increments each cycle.
//    done_rise -> CAPTURE. Counter reaches TIMEOUT_CYC with no rise -> ABANDON.
//    done_rise and timeout on same cycle: done_rise wins.
//    A stale high done_s is only accepted once it has been seen low.
//  - CAPTURE (1 cycle): result_out<=result_in, result_valid=1.
//  - ABANDON (1 cycle): timeout_err=1, err_count+1 saturating; result_out unchanged.
//  - After CAPTURE/ABANDON: job_idx==NUM_JOBS-1 -> FINISH, else job_idx+1 -> ASSERT.
//  - FINISH (1 cycle): all_done=1, -> IDLE; job_idx holds last index.
//  - go while busy is ignored (no queuing). go held high in IDLE after FINISH starts
//    a new batch the following cycle.
//  - Reset mid-batch: next edge returns to IDLE, start_asyn drops same edge, no
//    all_done pulse.
//  - Latency per job (no timeout): PULSE_CYC + cycles to done_rise + 1.
// TESTING
//  1 Reset: reset=1 2 cycles with go=1 -> all outputs 0, busy=0, state IDLE.
//  2 Nominal: NUM_JOBS=4, responder raises done_moore 5 cycles after start_asyn
//    fall with result_in=8'h10+idx -> result_valid x4 with 10,11,12,13; all_done once;
//    err_count=0; start_asyn high exactly 2 cycles per job.
//  3 Timeout: responder ignores job 2 -> timeout_err pulse after 255 WAIT_DONE cycles,
//    job 3 still issued, err_count=1, 3 result_valid pulses, all_done once.
//  4 Stale done: done_moore held high from job 0 through job 1 ASSERT, drops, rises
//    4 cycles later -> job 1 captured only after the rise, not immediately.
//  5 Race: done_rise on the exact cycle the timeout counter hits 255 -> CAPTURE,
//    no timeout_err.
//  6 Abort: reset asserted during WAIT_DONE of job 1 -> IDLE next cycle, start_asyn=0,
//    job_idx=0, no all_done; a new go then runs a full 4-job batch.

Source files
------------

// File: rtl/job_initiator.sv
// Host-side start/done initiator: issues NUM_JOBS start pulses per go, waits for each
// synchronised done rising edge, captures results and abandons jobs that time out.
module job_initiator #(
  parameter int NUM_JOBS    = 4,
  parameter int DATA_W      = 8,
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              done_moore,
  input  logic [DATA_W-1:0] result_in,
  output logic              start_asyn,
  output logic              busy,
  output logic [7:0]        job_idx,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid,
  output logic              timeout_err,
  output logic [7:0]        err_count,
  output logic              all_done
);

  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ASSERT, WAIT_DONE, CAPTURE, ABANDON, FINISH
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   done_s;
  logic                   done_prev_reg;
  logic                   seen_low_reg;
  logic                   done_rise;
  logic                   accept;
  logic [PW-1:0]          pulse_cnt_reg;
  logic [TW-1:0]          tout_cnt_reg;
  logic                   last_pulse;
  logic                   tout_hit;
  logic                   last_job;
  logic                   enter_assert;

  logic              start_asyn_reg, start_asyn_next;
  logic              busy_reg, busy_next;
  logic [7:0]        job_idx_reg, job_idx_next;
  logic [DATA_W-1:0] result_out_reg, result_out_next;
  logic              result_valid_reg, result_valid_next;
  logic              timeout_err_reg, timeout_err_next;
  logic [7:0]        err_count_reg, err_count_next;
  logic              all_done_reg, all_done_next;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clock) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= done_moore;
        end
      end else begin : g_next
        always_ff @(posedge clock) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign done_s       = sync_reg[SYNC_STAGES-1];
  assign done_rise    = done_s & ~done_prev_reg;
  // A level still high from the previous job only counts after it has been seen low.
  assign accept       = done_rise & seen_low_reg;
  assign last_pulse   = (pulse_cnt_reg == PW'(PULSE_CYC - 1));
  assign tout_hit     = (tout_cnt_reg == TW'(TIMEOUT_CYC - 1));
  assign last_job     = (job_idx_reg == 8'(NUM_JOBS - 1));
  assign enter_assert = (state_next == ASSERT) && (state_reg != ASSERT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      done_prev_reg <= 1'b0;
      seen_low_reg  <= 1'b0;
      pulse_cnt_reg <= '0;
      tout_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ASSERT && last_pulse) done_prev_reg <= 1'b0;
      else                                   done_prev_reg <= done_s;
      if (enter_assert)
        seen_low_reg <= 1'b0;
      else if (state_reg == ASSERT || state_reg == WAIT_DONE)
        seen_low_reg <= seen_low_reg | ~done_s;
      if (enter_assert)              pulse_cnt_reg <= '0;
      else if (state_reg == ASSERT)  pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
      if (enter_assert)              tout_cnt_reg <= '0;
      else if (state_reg == WAIT_DONE) tout_cnt_reg <= tout_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (go) state_next = ASSERT;
      ASSERT:    if (last_pulse) state_next = WAIT_DONE;
      WAIT_DONE: begin
        // A rise on the final waiting cycle still wins over the timeout.
        if (accept)        state_next = CAPTURE;
        else if (tout_hit) state_next = ABANDON;
      end
      CAPTURE,
      ABANDON:   state_next = last_job ? FINISH : ASSERT;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    start_asyn_next   = (state_next == ASSERT);
    busy_next         = (state_next != IDLE);
    result_valid_next = (state_next == CAPTURE);
    timeout_err_next  = (state_next == ABANDON);
    all_done_next     = (state_next == FINISH);
    job_idx_next      = job_idx_reg;
    err_count_next    = err_count_reg;
    result_out_next   = result_out_reg;
    if (state_reg == IDLE && go) begin
      job_idx_next   = 8'd0;
      err_count_next = 8'd0;
    end
    if (state_next == CAPTURE)
      result_out_next = result_in;
    if (state_next == ABANDON && err_count_reg != 8'hFF)
      err_count_next = err_count_reg + 8'd1;
    if ((state_reg == CAPTURE || state_reg == ABANDON) && !last_job)
      job_idx_next = job_idx_reg + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_asyn_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      job_idx_reg      <= 8'd0;
      result_out_reg   <= '0;
      result_valid_reg <= 1'b0;
      timeout_err_reg  <= 1'b0;
      err_count_reg    <= 8'd0;
      all_done_reg     <= 1'b0;
    end else begin
      start_asyn_reg   <= start_asyn_next;
      busy_reg         <= busy_next;
      job_idx_reg      <= job_idx_next;
      result_out_reg   <= result_out_next;
      result_valid_reg <= result_valid_next;
      timeout_err_reg  <= timeout_err_next;
      err_count_reg    <= err_count_next;
      all_done_reg     <= all_done_next;
    end
  end

  assign start_asyn   = start_asyn_reg;
  assign busy         = busy_reg;
  assign job_idx      = job_idx_reg;
  assign result_out   = result_out_reg;
  assign result_valid = result_valid_reg;
  assign timeout_err  = timeout_err_reg;
  assign err_count    = err_count_reg;
  assign all_done     = all_done_reg;

endmodule

// File: tb/tb_job_initiator.sv
// Bench for job_initiator: a scheduled responder drives done_moore; an event-level
// model predicts every start edge, capture, timeout, all_done and busy change.
module tb_job_initiator;
  localparam int NJ    = 4;
  localparam int PULSE = 2;
  localparam int TOUT  = 255;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       done_moore = 1'b0;
  logic [7:0] result_in = 8'd0;
  logic       start_asyn, busy, result_valid, timeout_err, all_done;
  logic [7:0] job_idx, result_out, err_count;

  int checks = 0;
  int fails  = 0;

  // kind: 0 start rise, 4 start fall, 1 capture, 2 timeout, 3 all_done, 5 busy change
  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] cyc;
    logic [7:0]  idx;
    logic [7:0]  val;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  int         cfg_delay[NJ];
  logic [7:0] cfg_val[NJ];
  bit         cfg_stale[NJ];
  int         drop_c[NJ], raise_c[NJ], fall_c[NJ];
  int         finish_c;
  int         exp_errs;

  job_initiator #(
    .NUM_JOBS(NJ), .DATA_W(8), .PULSE_CYC(PULSE), .TIMEOUT_CYC(TOUT), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .done_moore(done_moore), .result_in(result_in),
    .start_asyn(start_asyn), .busy(busy), .job_idx(job_idx), .result_out(result_out),
    .result_valid(result_valid), .timeout_err(timeout_err), .err_count(err_count),
    .all_done(all_done)
  );

  always #5 clock = ~clock;

  function automatic ev_t mk(input int kind, input int cyc, input int idx, input int val);
    ev_t e;
    e.kind = 4'(kind);
    e.cyc  = 16'(cyc);
    e.idx  = 8'(idx);
    e.val  = 8'(val);
    return e;
  endfunction

  // Cycle 0 is the first cycle after the go edge. Each job: start high PULSE cycles,
  // responder raises done d cycles after the start fall, the design sees it 2 flops
  // later and captures the cycle after; no rise within TOUT waiting cycles -> timeout.
  function automatic void build_model();
    int  r, f, e;
    bit  tmo;
    exp_q.delete();
    r = 0;
    exp_errs = 0;
    for (int j = 0; j < NJ; j++) begin
      f = r + PULSE;
      fall_c[j]  = f;
      drop_c[j]  = cfg_stale[j] ? f : r;
      raise_c[j] = (cfg_delay[j] < 0) ? -1 : f + cfg_delay[j];
      tmo = (cfg_delay[j] < 0) || (cfg_delay[j] > TOUT - 3);
      exp_q.push_back(mk(0, r, j, 0));
      if (j == 0) exp_q.push_back(mk(5, 0, 0, 1));
      exp_q.push_back(mk(4, f, j, 0));
      if (tmo) begin
        exp_errs = (exp_errs < 255) ? exp_errs + 1 : exp_errs;
        e = f + TOUT;
        exp_q.push_back(mk(2, e, j, exp_errs));
      end else begin
        e = f + cfg_delay[j] + 3;
        exp_q.push_back(mk(1, e, j, cfg_val[j]));
      end
      r = e + 1;
    end
    finish_c = r;
    exp_q.push_back(mk(3, finish_c, NJ - 1, exp_errs));
    exp_q.push_back(mk(5, finish_c + 1, 0, 0));
  endfunction

  function automatic void random_cfg();
    for (int j = 0; j < NJ; j++) begin
      cfg_delay[j] = int'($urandom_range(1, 20));
      cfg_val[j]   = 8'($urandom);
      cfg_stale[j] = 1'b0;
    end
  endfunction

  // Drives go plus the scheduled responder and records observed events up to stop_c.
  task automatic run_batch(input int stop_c);
    logic ps, pb;
    obs_q.delete();
    ps = 1'b0;
    pb = 1'b0;
    go = 1'b1;
    for (int c = 0; c <= stop_c; c++) begin
      @(posedge clock); #1;
      if (start_asyn && !ps) obs_q.push_back(mk(0, c, job_idx, 0));
      if (!start_asyn && ps) obs_q.push_back(mk(4, c, job_idx, 0));
      if (result_valid) begin
        obs_q.push_back(mk(1, c, job_idx, result_out));
        $display("cycle %0d: job %0d result %h", c, job_idx, result_out);
      end
      if (timeout_err) begin
        obs_q.push_back(mk(2, c, job_idx, err_count));
        $display("cycle %0d: job %0d abandoned, err_count %0d", c, job_idx, err_count);
      end
      if (all_done) obs_q.push_back(mk(3, c, job_idx, err_count));
      if (busy != pb) obs_q.push_back(mk(5, c, 0, {7'd0, busy}));
      ps = start_asyn;
      pb = busy;
      go = 1'b0;
      for (int j = 0; j < NJ; j++) begin
        if (c == fall_c[j]) go = 1'b1;
        if (c == drop_c[j]) begin
          done_moore = 1'b0;
          result_in  = 8'($urandom);
        end
        if (c == raise_c[j]) begin
          done_moore = 1'b1;
          result_in  = cfg_val[j];
        end
      end
    end
    go = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (start_asyn !== 1'b0)   begin fails++; $display("FAIL reset start_asyn: got %b want 0", start_asyn); end
    checks++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (job_idx !== 8'd0)      begin fails++; $display("FAIL reset job_idx: got %0d want 0", job_idx); end
    checks++; if (result_out !== 8'd0)   begin fails++; $display("FAIL reset result_out: got %h want 0", result_out); end
    checks++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset result_valid: got %b want 0", result_valid); end
    checks++; if (timeout_err !== 1'b0)  begin fails++; $display("FAIL reset timeout_err: got %b want 0", timeout_err); end
    checks++; if (err_count !== 8'd0)    begin fails++; $display("FAIL reset err_count: got %0d want 0", err_count); end
    checks++; if (all_done !== 1'b0)     begin fails++; $display("FAIL reset all_done: got %b want 0", all_done); end
    go    = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset idle_after: busy %b want 0", busy); end
  endtask

  task automatic test_nominal();
    for (int b = 0; b < 4; b++) begin
      if (b == 0) begin
        for (int j = 0; j < NJ; j++) begin
          cfg_delay[j] = 5; cfg_val[j] = 8'h10 + 8'(j); cfg_stale[j] = 1'b0;
        end
      end else random_cfg();
      build_model();
      run_batch(finish_c + 1);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        fails++; $display("FAIL nominal%0d count: got %0d events want %0d", b, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL nominal%0d ev%0d: got k%0d c%0d i%0d v%h want k%0d c%0d i%0d v%h", b, i,
                   obs_q[i].kind, obs_q[i].cyc, obs_q[i].idx, obs_q[i].val,
                   exp_q[i].kind, exp_q[i].cyc, exp_q[i].idx, exp_q[i].val);
        end
      end
      checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL nominal%0d err_count: got %0d want 0", b, err_count); end
    end
  endtask

  task automatic test_timeout();
    int caps;
    random_cfg();
    cfg_delay[2] = -1;
    build_model();
    run_batch(finish_c + 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL timeout count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL timeout ev%0d: got k%0d c%0d i%0d v%h want k%0d c%0d i%0d v%h", i,
                 obs_q[i].kind, obs_q[i].cyc, obs_q[i].idx, obs_q[i].val,
                 exp_q[i].kind, exp_q[i].cyc, exp_q[i].idx, exp_q[i].val);
      end
    end
    caps = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == 4'd1) caps++;
    checks++; if (caps != 3) begin fails++; $display("FAIL timeout captures: got %0d want 3", caps); end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL timeout err_count: got %0d want 1", err_count); end
  endtask

  task automatic test_stale();
    int cap_c;
    random_cfg();
    cfg_delay[0] = 5;
    cfg_delay[1] = 4;
    cfg_stale[1] = 1'b1;
    build_model();
    run_batch(finish_c + 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL stale count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stale ev%0d: got k%0d c%0d i%0d v%h want k%0d c%0d i%0d v%h", i,
                 obs_q[i].kind, obs_q[i].cyc, obs_q[i].idx, obs_q[i].val,
                 exp_q[i].kind, exp_q[i].cyc, exp_q[i].idx, exp_q[i].val);
      end
    end
    cap_c = -1;
    foreach (obs_q[i]) if (obs_q[i].kind == 4'd1 && obs_q[i].idx == 8'd1 && cap_c < 0) cap_c = int'(obs_q[i].cyc);
    checks++;
    if (cap_c != fall_c[1] + 7) begin
      fails++; $display("FAIL stale job1_capture_cycle: got %0d want %0d", cap_c, fall_c[1] + 7);
    end
  endtask

  task automatic test_race();
    random_cfg();
    cfg_delay[0] = 3;
    cfg_delay[1] = TOUT - 3;
    cfg_delay[2] = TOUT - 2;
    cfg_delay[3] = 2;
    build_model();
    run_batch(finish_c + 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL race count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL race ev%0d: got k%0d c%0d i%0d v%h want k%0d c%0d i%0d v%h", i,
                 obs_q[i].kind, obs_q[i].cyc, obs_q[i].idx, obs_q[i].val,
                 exp_q[i].kind, exp_q[i].cyc, exp_q[i].idx, exp_q[i].val);
      end
    end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL race err_count: got %0d want 1", err_count); end
  endtask

  task automatic test_abort();
    int bad;
    random_cfg();
    cfg_delay[0] = 3;
    cfg_delay[1] = -1;
    build_model();
    run_batch(fall_c[1] + 5);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    done_moore = 1'b0;
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL abort busy: got %b want 0", busy); end
    checks++; if (start_asyn !== 1'b0) begin fails++; $display("FAIL abort start_asyn: got %b want 0", start_asyn); end
    checks++; if (job_idx !== 8'd0)    begin fails++; $display("FAIL abort job_idx: got %0d want 0", job_idx); end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (all_done !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL abort quiet: got %0d active cycles want 0", bad); end
    random_cfg();
    build_model();
    run_batch(finish_c + 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL abort_rerun count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL abort_rerun ev%0d: got k%0d c%0d i%0d v%h want k%0d c%0d i%0d v%h", i,
                 obs_q[i].kind, obs_q[i].cyc, obs_q[i].idx, obs_q[i].val,
                 exp_q[i].kind, exp_q[i].cyc, exp_q[i].idx, exp_q[i].val);
      end
    end
  endtask

  task automatic test_back_to_back();
    random_cfg();
    cfg_delay[1] = -1;
    build_model();
    exp_q.pop_back();
    run_batch(finish_c);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b ev%0d: got k%0d c%0d i%0d v%h want k%0d c%0d i%0d v%h", i,
                 obs_q[i].kind, obs_q[i].cyc, obs_q[i].idx, obs_q[i].val,
                 exp_q[i].kind, exp_q[i].cyc, exp_q[i].idx, exp_q[i].val);
      end
    end
    go = 1'b1;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL b2b idle_busy: got %b want 0", busy); end
    checks++; if (start_asyn !== 1'b0) begin fails++; $display("FAIL b2b idle_start: got %b want 0", start_asyn); end
    @(posedge clock); #1;
    go = 1'b0;
    checks++; if (start_asyn !== 1'b1) begin fails++; $display("FAIL b2b restart_start: got %b want 1", start_asyn); end
    checks++; if (busy !== 1'b1)       begin fails++; $display("FAIL b2b restart_busy: got %b want 1", busy); end
    checks++; if (job_idx !== 8'd0)    begin fails++; $display("FAIL b2b restart_idx: got %0d want 0", job_idx); end
    checks++; if (err_count !== 8'd0)  begin fails++; $display("FAIL b2b restart_errs: got %0d want 0", err_count); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    done_moore = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_stale();
    test_race();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
